// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if -- the two read-request ports of rom_arbiter.
//
// Each port N carries:
//   reqN_valid  requester -> arbiter  read request
//   reqN_addr   requester -> arbiter  8-bit byte address
//   reqN_ready  arbiter -> requester  request accepted this cycle
//   rspN_valid  arbiter -> requester  one-cycle read data valid pulse
//   rspN_data   arbiter -> requester  read data, held until the next response
//
// Modports: master = requester side, slave = arbiter side.
interface rom_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_addr;
  logic       req0_ready;
  logic       rsp0_valid;
  logic [7:0] rsp0_data;

  logic       req1_valid;
  logic [7:0] req1_addr;
  logic       req1_ready;
  logic       rsp1_valid;
  logic [7:0] rsp1_data;

  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter -- shares one 256x8 asynchronous ROM between two read ports.
//
// A request is accepted in IDLE, its address is registered onto rom_addr, and
// rom_data is sampled WAIT_CYCLES clocks later to cover the ROM access time.
// The data is returned with a one-cycle rspN_valid pulse on the granted port.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   bus       rom_arbiter_if.slave, request/response signals of ports 0 and 1
//   rom_addr  registered ROM address, holds between transactions
//   rom_data  ROM read data
//   busy      high whenever the FSM is not in IDLE
//
// Parameter WAIT_CYCLES (1..15): clocks from rom_addr update to rom_data sample.
//
// Build option ROM_ARB_ROUND_ROBIN_EN: when defined, simultaneous requests go to
// the port not granted last; when undefined, port 0 has fixed priority.
//
// state | meaning
// IDLE  | ready asserted for the arbitration winner, waiting for a request
// WAIT  | rom_addr driven, counting down the ROM access time
// DONE  | rspN_valid pulse for the granted port
module rom_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  rom_arbiter_if.slave bus,
  output logic [7:0]   rom_addr,
  input  logic [7:0]   rom_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] WAIT_LD = WAIT_CYCLES[3:0];

  state_t     state;
  logic [3:0] cnt;
  logic       gnt_port;
  logic       rsp0_valid_q;
  logic       rsp1_valid_q;
  logic [7:0] rsp0_data_q;
  logic [7:0] rsp1_data_q;
  logic       sel1;
  logic       accept;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic       last_grant;

  // Port 1 wins alone, or on a tie when port 0 was the last one served.
  assign sel1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
`else
  assign sel1 = bus.req1_valid && !bus.req0_valid;
`endif

  assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !sel1;
  assign bus.req1_ready = (state == IDLE) && sel1;
  assign accept         = bus.req0_ready || bus.req1_ready;

  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_data  = rsp1_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rom_addr     <= 8'h00;
      cnt          <= 4'd0;
      gnt_port     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= 8'h00;
      rsp1_data_q  <= 8'h00;
      busy         <= 1'b0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rom_addr <= sel1 ? bus.req1_addr : bus.req0_addr;
            gnt_port <= sel1;
            cnt      <= WAIT_LD;
            busy     <= 1'b1;
            state    <= WAIT;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            last_grant <= sel1;
`endif
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          // <= 1 rather than == 1 so a stray zero count cannot lock the FSM.
          if (cnt <= 4'd1) begin
            if (gnt_port) begin
              rsp1_data_q  <= rom_data;
              rsp1_valid_q <= 1'b1;
            end else begin
              rsp0_data_q  <= rom_data;
              rsp0_valid_q <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter -- directed bench for rom_arbiter.
// dut_a runs with WAIT_CYCLES=2, dut_b with WAIT_CYCLES=1; both read a shared
// ROM model. Expected responses go into sbq; the negedge monitor pops and
// compares every rspN_valid pulse (instance, port, data, arrival cycle).
module tb_rom_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] rom_addr_a, rom_addr_b;
  logic [7:0] rom_data_a, rom_data_b;
  logic       busy_a, busy_b;
  logic [7:0] rom [256];

  rom_arbiter_if bus_a();
  rom_arbiter_if bus_b();

  assign rom_data_a = rom[rom_addr_a];
  assign rom_data_b = rom[rom_addr_b];

  rom_arbiter #(.WAIT_CYCLES(2)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_a),
    .rom_addr (rom_addr_a),
    .rom_data (rom_data_a),
    .busy     (busy_a)
  );

  rom_arbiter #(.WAIT_CYCLES(1)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_b),
    .rom_addr (rom_addr_b),
    .rom_data (rom_data_b),
    .busy     (busy_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         inst;
    int         port;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic pop_cmp(input int inst, input int port, input logic [7:0] data);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rsp: inst %0d port %0d data 0x%02h at cycle %0d, none expected",
               inst, port, data, cyc);
    end else begin
      e = sbq.pop_front();
      chk("rsp_inst", inst, e.inst);
      chk("rsp_port", port, e.port);
      chk("rsp_data", {24'd0, data}, {24'd0, e.data});
      chk("rsp_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus_a.rsp0_valid === 1'b1) pop_cmp(0, 0, bus_a.rsp0_data);
    if (bus_a.rsp1_valid === 1'b1) pop_cmp(0, 1, bus_a.rsp1_data);
    if (bus_b.rsp0_valid === 1'b1) pop_cmp(1, 0, bus_b.rsp0_data);
    if (bus_b.rsp1_valid === 1'b1) pop_cmp(1, 1, bus_b.rsp1_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input int max, input string name);
    int n = 0;
    while (sbq.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d responses still pending after %0d cycles", name, sbq.size(), max);
      sbq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    int p;
    for (int i = 0; i < 256; i++) rom[i] = 8'((i * 7 + 3) & 255);
    rom[8'h10] = 8'hA5;
    rom[8'hFF] = 8'h3C;
    // ROM[0x01]=0x0A, ROM[0x02]=0x11, ROM[0x20]=0xE3, ROM[0x30]=0x53

    rst_n = 1'b0;
    bus_a.req0_valid = 1'b0; bus_a.req0_addr = 8'h00;
    bus_a.req1_valid = 1'b0; bus_a.req1_addr = 8'h00;
    bus_b.req0_valid = 1'b0; bus_b.req0_addr = 8'h00;
    bus_b.req1_valid = 1'b0; bus_b.req1_addr = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state after 5 idle cycles
    repeat (5) tick();
    neg();
    chk("rst_busy_a", busy_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_ready0", bus_a.req0_ready, 0);
    chk("rst_ready1", bus_a.req1_ready, 0);
    chk("rst_rsp0_valid", bus_a.rsp0_valid, 0);
    chk("rst_rsp1_valid", bus_a.rsp1_valid, 0);
    chk("rst_rsp0_data", bus_a.rsp0_data, 0);
    chk("rst_rsp1_data", bus_a.rsp1_data, 0);
    chk("rst_rom_addr", rom_addr_a, 0);

    // Single port 0 read of 0x10, WAIT_CYCLES=2
    tick();
    bus_a.req0_addr = 8'h10;
    bus_a.req0_valid = 1'b1;
    neg();
    chk("single_ready0", bus_a.req0_ready, 1);
    chk("single_ready1", bus_a.req1_ready, 0);
    sbq.push_back('{0, 0, 8'hA5, cyc + 3});
    tick();
    bus_a.req0_valid = 1'b0;
    neg();
    chk("single_busy", busy_a, 1);
    chk("single_rom_addr", rom_addr_a, 8'h10);
    drain(20, "single_drain");
    chk("single_rsp0_data", bus_a.rsp0_data, 8'hA5);
    chk("single_rsp1_data", bus_a.rsp1_data, 8'h00);

    // Both ports held valid: one grant every 4 cycles
    do_reset();
    bus_a.req0_addr = 8'h01;
    bus_a.req1_addr = 8'h02;
    bus_a.req0_valid = 1'b1;
    bus_a.req1_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      neg();
      if (i % 4 == 0) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
        p = (i / 4) % 2;
`else
        p = 0;
`endif
        chk("both_ready0", bus_a.req0_ready, (p == 0) ? 1 : 0);
        chk("both_ready1", bus_a.req1_ready, (p == 1) ? 1 : 0);
        sbq.push_back('{0, p, (p == 1) ? 8'h11 : 8'h0A, cyc + 3});
      end else begin
        chk("both_busy_ready0", bus_a.req0_ready, 0);
        chk("both_busy_ready1", bus_a.req1_ready, 0);
      end
    end
    tick();
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
    drain(20, "both_drain");

    // Reset during the WAIT of a port 1 read aborts it
    do_reset();
    bus_a.req1_addr = 8'h20;
    bus_a.req1_valid = 1'b1;
    neg();
    chk("abort_ready1", bus_a.req1_ready, 1);
    chk("abort_ready0", bus_a.req0_ready, 0);
    tick();
    bus_a.req1_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    neg();
    chk("abort_busy", busy_a, 0);
    repeat (4) neg();
    chk("abort_rsp1_data", bus_a.rsp1_data, 8'h00);
    chk("abort_rom_addr", rom_addr_a, 8'h00);
    tick();
    bus_a.req0_addr = 8'h01;
    bus_a.req1_addr = 8'h02;
    bus_a.req0_valid = 1'b1;
    bus_a.req1_valid = 1'b1;
    neg();
    chk("post_abort_ready0", bus_a.req0_ready, 1);
    chk("post_abort_ready1", bus_a.req1_ready, 0);
    sbq.push_back('{0, 0, 8'h0A, cyc + 3});
    tick();
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
    drain(20, "post_abort_drain");

    // Port 1 pulses valid for one cycle while busy: ignored
    tick();
    bus_a.req0_addr = 8'h30;
    bus_a.req0_valid = 1'b1;
    neg();
    chk("drop_ready0", bus_a.req0_ready, 1);
    sbq.push_back('{0, 0, 8'h53, cyc + 3});
    tick();
    bus_a.req0_valid = 1'b0;
    bus_a.req1_addr = 8'h40;
    bus_a.req1_valid = 1'b1;
    neg();
    chk("drop_ready1", bus_a.req1_ready, 0);
    chk("drop_busy", busy_a, 1);
    tick();
    bus_a.req1_valid = 1'b0;
    drain(20, "drop_drain");
    repeat (4) neg();
    chk("hold_rom_addr", rom_addr_a, 8'h30);
    chk("hold_rsp0_data", bus_a.rsp0_data, 8'h53);
    chk("hold_rsp1_data", bus_a.rsp1_data, 8'h00);
    chk("hold_busy", busy_a, 0);

    // WAIT_CYCLES=1, address 0xFF on port 1
    tick();
    bus_b.req1_addr = 8'hFF;
    bus_b.req1_valid = 1'b1;
    neg();
    chk("w1_ready1", bus_b.req1_ready, 1);
    sbq.push_back('{1, 1, 8'h3C, cyc + 2});
    tick();
    bus_b.req1_valid = 1'b0;
    drain(20, "w1_drain");
    chk("w1_rom_addr", rom_addr_b, 8'hFF);
    chk("w1_rsp1_data", bus_b.rsp1_data, 8'h3C);
    chk("w1_rsp0_data", bus_b.rsp0_data, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, clock cycles between the rom_addr update and the rom_data sample; legal range 1..15; sized to cover the 150 ns ROM access time.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid  input  1  port 0 read request.
REQ-005 req0_addr  input  8  port 0 byte address.
REQ-006 req0_ready  output  1  port 0 request accepted this cycle.
REQ-007 rsp0_valid  output  1  port 0 read data valid, one-cycle pulse.
REQ-008 rsp0_data  output  8  port 0 read data.
REQ-009 req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data SHALL mirror REQ-004..REQ-008 for port 1.
REQ-010 rom_addr  output  8  registered address driven to the 256x8 ROM.
REQ-011 rom_data  input  8  ROM data output.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-014 In IDLE, reqN_ready SHALL be combinationally high only for the port selected by arbitration whose reqN_valid is high; at most one ready is high per cycle.
REQ-015 A transaction SHALL start on an edge where reqN_valid and reqN_ready are both high: latch reqN_addr into rom_addr, record the granted port, load the wait counter with WAIT_CYCLES, then IDLE->WAIT.
REQ-016 In WAIT, the counter SHALL decrement each cycle; on the edge where the counter equals 1, rom_data SHALL be captured into the granted port's rsp data register, then WAIT->DONE.
REQ-017 In DONE, rspN_valid SHALL be high for exactly one cycle for the granted port only; DONE->IDLE unconditionally.
REQ-018 Latency from the accept edge to the first rspN_valid cycle SHALL be WAIT_CYCLES+1 cycles; back-to-back throughput SHALL be one transaction per WAIT_CYCLES+2 cycles.
REQ-019 No request SHALL be accepted in WAIT or DONE; reqN_ready SHALL be 0 there.
REQ-020 rom_addr SHALL hold its last value between transactions; rspN_data SHALL hold until that port's next response.
REQ-021 A requester deasserting reqN_valid before ready SHALL cause no transaction and no state change.
REQ-022 Addresses SHALL be used unmodified: 0xFF is legal, with no wrap and no range check.

Reset
REQ-023 While rst_n is 0 at a rising edge: state=IDLE, rom_addr=0x00, rsp0_data=rsp1_data=0x00, counter=0, last-grant pointer=1; all ready/valid outputs and busy SHALL be 0 in the following cycle.
REQ-024 Reset asserted in WAIT or DONE SHALL abort the transaction; no rspN_valid pulse is issued for it.

Configuration
REQ-025 Macro ROM_ARB_ROUND_ROBIN_EN.
REQ-026 Defined: when both ports are valid in IDLE, the grant SHALL go to the port not granted last; the pointer updates only on an accepted transaction.
REQ-027 Undefined: fixed priority; port 0 SHALL always win a simultaneous request; no pointer register.
REQ-028 A single-port request SHALL be granted immediately in both builds.

Verification
REQ-029 Reset, then idle 5 cycles -> all outputs 0, rom_addr=0x00, busy=0.
REQ-030 WAIT_CYCLES=2, ROM[0x10]=0xA5, req0 addr 0x10 -> req0_ready in the first cycle, rsp0_valid 3 cycles after the accept edge, rsp0_data=0xA5, port 1 outputs unchanged.
REQ-031 Both ports valid continuously, addr0=0x01, addr1=0x02, round-robin build -> grants alternate 0,1,0,1 with one grant every 4 cycles; fixed-priority build -> port 0 only, port 1 starved while req0 is held.
REQ-032 rst_n pulsed low in the WAIT cycle of a port 1 read -> no rsp1_valid, rsp1_data=0x00, next grant follows reset pointer.
REQ-033 req1_valid held for 1 cycle while the arbiter is busy, then dropped -> no port 1 transaction and no rsp1_valid.
REQ-034 WAIT_CYCLES=1, addr 0xFF with ROM[0xFF]=0x3C -> rsp valid 2 cycles after accept, data 0x3C.
